// File: rtl/dpram_ctrl_pkg.sv
// Shared definitions for the dual-port RAM port arbiter.
//   state_e        : controller state encoding (ST_CLEAR / ST_RUN)
//   GNT_R0/GNT_R1  : requester index encoding used for grant history and read ownership
//   DEFAULT_*      : default RAM geometry
package dpram_ctrl_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic GNT_R0 = 1'b0;
    localparam logic GNT_R1 = 1'b1;

    localparam int DEFAULT_ADDR_W = 12;
    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/dpram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset_n : clock and asynchronous active-low reset
//   valid[1:0]   : request lines (bit 0 = requester 0)
//   xfer         : a granted request was accepted this cycle
//   grant[1:0]   : combinational one-hot grant (or zero)
//   last_grant   : index of the most recently accepted requester; resets to 1
//                  so requester 0 wins the first tie
module rr_arb2
    import dpram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       xfer,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == GNT_R1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = grant[1] ? GNT_R1 : GNT_R0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GNT_R1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one RAM port between two requesters with round-robin arbitration,
// optionally zero-fills the RAM after reset, and routes one-cycle-latency
// read data back to the requester that issued the read.
//   clk, reset_n          : clock and asynchronous active-low reset
//   init_done             : RAM usable (clear finished or skipped)
//   rN_valid/ready/we/addr/wdata : requester N access channel
//   rN_rvalid/rdata       : requester N read return
//   mem_ce/we/addr/write  : RAM port controls and write data
//   mem_read              : RAM port read data, one cycle after the read
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing zero to clear_addr each cycle, requesters blocked
// ST_RUN   | arbitrating requester traffic onto the RAM port
module dpram_port_arbiter
    import dpram_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              init_done,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write,
    input  logic [DATA_W-1:0] mem_read
);

    localparam state_e ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
    logic              init_done_q, init_done_d;
    logic              rd_pending_q, rd_pending_d;

    logic [1:0]        arb_valid;
    logic [1:0]        grant;
    logic              last_grant;
    logic              rd_owner;

    // Requesters are invisible to the arbiter while clearing.
    assign arb_valid = (state_q == ST_RUN) ? {r1_valid, r0_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (arb_valid),
        .xfer       (|grant),
        .grant      (grant),
        .last_grant (last_grant)
    );

    // rd_pending_q is only set in the cycle right after a read transfer, and
    // the arbiter's history was updated on that same edge to the reading
    // requester, so last_grant is the owner whenever a response is due.
    assign rd_owner = last_grant;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        init_done_d  = init_done_q;
        rd_pending_d = 1'b0;
        mem_ce       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_write    = '0;
        unique case (state_q)
            ST_CLEAR: begin
                mem_ce       = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = clear_addr_q;
                clear_addr_d = clear_addr_q + 1'b1;
                if (clear_addr_q == {ADDR_W{1'b1}}) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (grant[0]) begin
                    mem_ce       = 1'b1;
                    mem_we       = r0_we;
                    mem_addr     = r0_addr;
                    mem_write    = r0_wdata;
                    rd_pending_d = !r0_we;
                end else if (grant[1]) begin
                    mem_ce       = 1'b1;
                    mem_we       = r1_we;
                    mem_addr     = r1_addr;
                    mem_write    = r1_wdata;
                    rd_pending_d = !r1_we;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RESET;
            clear_addr_q <= '0;
            init_done_q  <= !CLEAR_ON_RESET;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            init_done_q  <= init_done_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign init_done = init_done_q;
    assign r0_ready  = grant[0];
    assign r1_ready  = grant[1];
    assign r0_rvalid = rd_pending_q && (rd_owner == GNT_R0);
    assign r1_rvalid = rd_pending_q && (rd_owner == GNT_R1);
    assign r0_rdata  = mem_read;
    assign r1_rdata  = mem_read;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          init_done;
    logic          r0_valid, r0_ready, r0_we, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_ready, r1_we, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write, mem_read;

    logic [DW-1:0] ram [2**AW];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init_done (init_done),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_read  (mem_read)
    );

    // Synchronous single-port RAM behaviour with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= mem_write;
            else        mem_read      <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a posedge with reset released; checks n clear cycles.
    task automatic run_clear(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r0_valid = 1'b1;
            r1_valid = 1'b1;
            #1;
            chk("clr_ctl", {27'd0, mem_ce, mem_we, r0_ready, r1_ready, init_done}, 32'b11000);
            chk("clr_addr", {28'd0, mem_addr}, i);
            chk("clr_wdata", {16'd0, mem_write}, 32'h0);
            @(posedge clk);
            #1;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {29'd0, init_done, r0_rvalid, r1_rvalid}, 32'h0);

        // Power-up clear of 16 words.
        reset_n = 1'b1;
        run_clear(16);
        chk("clr_done", {31'd0, init_done}, 32'h1);

        // r0 writes 0xBEEF to 0x3.
        @(negedge clk);
        drive0(1'b1, 1'b1, 4'h3, 16'hBEEF);
        #1;
        chk("wr0_rdy", {30'd0, r0_ready, r1_ready}, 32'b10);
        chk("wr0_mem", {10'd0, mem_ce, mem_we, mem_addr, mem_write}, {10'd0, 1'b1, 1'b1, 4'h3, 16'hBEEF});
        @(posedge clk); #1;
        chk("wr0_norv", {30'd0, r0_rvalid, r1_rvalid}, 32'b00);

        // r1 reads 0x3 back.
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b0, 4'h3, 16'h0);
        #1;
        chk("rd1_rdy", {30'd0, r0_ready, r1_ready}, 32'b01);
        chk("rd1_mem", {30'd0, mem_ce, mem_we}, 32'b10);
        @(posedge clk); #1;
        chk("rd1_rv", {30'd0, r0_rvalid, r1_rvalid}, 32'b01);
        chk("rd1_data", {16'd0, r1_rdata}, 32'hBEEF);

        // Only r1 valid: three back-to-back writes, granted every cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive1(1'b1, 1'b1, (k == 2) ? 4'h5 : 4'(k + 1), 16'h1111 * DW'(k + 1));
            #1;
            chk("wr1_rdy", {30'd0, r0_ready, r1_ready}, 32'b01);
            chk("wr1_we", {30'd0, mem_ce, mem_we}, 32'b11);
            @(posedge clk); #1;
            chk("wr1_norv", {30'd0, r0_rvalid, r1_rvalid}, 32'b00);
        end

        // Both read continuously: r0 at 0x1 (0x1111), r1 at 0x2 (0x2222).
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive0(1'b1, 1'b0, 4'h1, 16'h0);
            drive1(1'b1, 1'b0, 4'h2, 16'h0);
            #1;
            chk("alt_rdy", {30'd0, r0_ready, r1_ready}, (k % 2 == 0) ? 32'b10 : 32'b01);
            @(posedge clk); #1;
            chk("alt_rv", {30'd0, r0_rvalid, r1_rvalid}, (k % 2 == 0) ? 32'b10 : 32'b01);
            chk("alt_data", {16'd0, (k % 2 == 0) ? r0_rdata : r1_rdata},
                (k % 2 == 0) ? 32'h1111 : 32'h2222);
        end
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        #1;
        chk("idle_ce", {31'd0, mem_ce}, 32'h0);
        @(posedge clk); #1;
        chk("idle_rv", {30'd0, r0_rvalid, r1_rvalid}, 32'b00);

        // Reset during RUN, then interrupt the following clear at address 7.
        reset_n = 1'b0;
        #1;
        chk("rst_run", {31'd0, init_done}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_clear(7);
        @(negedge clk); #1;
        chk("clr_at7", {28'd0, mem_addr}, 32'h7);
        reset_n = 1'b0;
        #1;
        chk("rst_mid", {27'd0, init_done, mem_addr}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_clear(16);
        chk("reclr_done", {31'd0, init_done}, 32'h1);

        // r0 read accepted combinationally, reset lands on the edge that would take it.
        @(negedge clk);
        drive0(1'b1, 1'b0, 4'h3, 16'h0);
        #1;
        chk("drop_rdy", {31'd0, r0_ready}, 32'h1);
        #3;
        reset_n = 1'b0;
        @(posedge clk); #1;
        drive0(1'b0, 1'b0, '0, '0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            seen = seen | r0_rvalid | r1_rvalid;
            if (k == 2) reset_n = 1'b1;
            @(posedge clk); #1;
        end
        chk("drop_rv", {31'd0, seen}, 32'h0);
        chk("drop_done", {31'd0, init_done}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
